// File: rtl/wishbone_mux_n_pkg.sv
// Shared types and constants for the Wishbone 1-to-N address-decoded mux.
package wishbone_mux_n_pkg;

  localparam int unsigned MAX_SLAVES = 8;
  localparam int unsigned TMO_CNT_W  = 16;
  localparam int unsigned IDX_W      = 3;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StBusy = 2'd1,
    StResp = 2'd2
  } state_e;

endpackage

// File: rtl/wb_addr_decoder.sv
// Combinational address decoder: flags a hit and returns the lowest matching slot.
module wb_addr_decoder
  import wishbone_mux_n_pkg::*;
#(
  parameter int unsigned              NUM_SLAVES = 3,
  parameter logic [NUM_SLAVES*32-1:0] BASE_ADDR  = {32'h3000_8000, 32'h3000_4000, 32'h3000_0000},
  parameter logic [NUM_SLAVES*8-1:0]  ADDR_WIDTH = {8'd12, 8'd11, 8'd11}
) (
  input  logic [31:0]      i_adr,
  output logic             o_hit,
  output logic [IDX_W-1:0] o_idx
);

  // Compare only the bits above the window; a window of 32 or more bits matches everything.
  function automatic logic slot_match(input logic [31:0] adr, input logic [31:0] base,
                                      input logic [7:0] aw);
    logic [31:0] mask;
    mask = (aw >= 8'd32) ? 32'h0 : (32'hFFFF_FFFF << aw);
    return ((adr ^ base) & mask) == 32'h0;
  endfunction

  // Scan from the top slot down so the lowest matching index is the one left standing.
  always_comb begin
    o_hit = 1'b0;
    o_idx = '0;
    for (int i = int'(NUM_SLAVES) - 1; i >= 0; i--) begin
      if (slot_match(i_adr, BASE_ADDR[32*i +: 32], ADDR_WIDTH[8*i +: 8])) begin
        o_hit = 1'b1;
        o_idx = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/wishbone_mux_n.sv
// Wishbone 1-to-N mux: decodes the upstream address, forwards one transfer at a time
// to the selected slave, and returns a registered one-cycle ack/err with timeout.
module wishbone_mux_n
  import wishbone_mux_n_pkg::*;
#(
  parameter int unsigned              NUM_SLAVES     = 3,
  parameter logic [NUM_SLAVES*32-1:0] BASE_ADDR      = {32'h3000_8000, 32'h3000_4000,
                                                        32'h3000_0000},
  parameter logic [NUM_SLAVES*8-1:0]  ADDR_WIDTH     = {8'd12, 8'd11, 8'd11},
  parameter int unsigned              TIMEOUT_CYCLES = 255
) (
  input  logic                      wb_clk_i,
  input  logic                      wb_rstn_i,
  // upstream
  input  logic                      wbs_cyc_i,
  input  logic                      wbs_stb_i,
  input  logic                      wbs_we_i,
  input  logic [3:0]                wbs_sel_i,
  input  logic [31:0]               wbs_adr_i,
  input  logic [31:0]               wbs_dat_i,
  output logic                      wbs_ack_o,
  output logic                      wbs_err_o,
  output logic [31:0]               wbs_dat_o,
  // downstream
  output logic [NUM_SLAVES-1:0]     wbm_cyc_o,
  output logic [NUM_SLAVES-1:0]     wbm_stb_o,
  output logic [NUM_SLAVES-1:0]     wbm_we_o,
  output logic [4*NUM_SLAVES-1:0]   wbm_sel_o,
  output logic [32*NUM_SLAVES-1:0]  wbm_adr_o,
  output logic [32*NUM_SLAVES-1:0]  wbm_dat_o,
  input  logic [NUM_SLAVES-1:0]     wbm_ack_i,
  input  logic [NUM_SLAVES-1:0]     wbm_err_i,
  input  logic [32*NUM_SLAVES-1:0]  wbm_dat_i,
  // status
  output logic                      tmo_o,
  output logic [31:0]               tmo_addr_o
);

  localparam logic [TMO_CNT_W-1:0] TmoLast = TMO_CNT_W'(TIMEOUT_CYCLES - 1);

  state_e               r_state, w_state_nxt;
  logic [IDX_W-1:0]     r_idx, w_idx_nxt;
  logic [31:0]          r_adr, w_adr_nxt;
  logic [31:0]          r_wdat, w_wdat_nxt;
  logic [3:0]           r_sel, w_sel_nxt;
  logic                 r_we, w_we_nxt;
  logic [TMO_CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic                 r_ack, w_ack_nxt;
  logic                 r_err, w_err_nxt;
  logic [31:0]          r_rdat, w_rdat_nxt;
  logic                 r_tmo, w_tmo_nxt;
  logic [31:0]          r_tmo_addr, w_tmo_addr_nxt;

  logic                 w_hit;
  logic [IDX_W-1:0]     w_hit_idx;
  logic                 w_sel_ack;
  logic                 w_sel_err;
  logic [31:0]          w_sel_dat;

  wb_addr_decoder #(
    .NUM_SLAVES (NUM_SLAVES),
    .BASE_ADDR  (BASE_ADDR),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_dec (
    .i_adr (wbs_adr_i),
    .o_hit (w_hit),
    .o_idx (w_hit_idx)
  );

  // Pick out the response lines of the slave currently owning the transfer.
  always_comb begin
    w_sel_ack = 1'b0;
    w_sel_err = 1'b0;
    w_sel_dat = '0;
    for (int i = 0; i < int'(NUM_SLAVES); i++) begin
      if (r_idx == IDX_W'(i)) begin
        w_sel_ack = wbm_ack_i[i];
        w_sel_err = wbm_err_i[i];
        w_sel_dat = wbm_dat_i[32*i +: 32];
      end
    end
  end

  // Drive the latched request to the selected slave only while BUSY; everything else is 0.
  always_comb begin
    wbm_cyc_o = '0;
    wbm_stb_o = '0;
    wbm_we_o  = '0;
    wbm_sel_o = '0;
    wbm_adr_o = '0;
    wbm_dat_o = '0;
    for (int i = 0; i < int'(NUM_SLAVES); i++) begin
      if (r_state == StBusy && r_idx == IDX_W'(i)) begin
        wbm_cyc_o[i]          = 1'b1;
        wbm_stb_o[i]          = 1'b1;
        wbm_we_o[i]           = r_we;
        wbm_sel_o[4*i +: 4]   = r_sel;
        wbm_adr_o[32*i +: 32] = r_adr;
        wbm_dat_o[32*i +: 32] = r_wdat;
      end
    end
  end

  // Next-state and registered-response logic.
  always_comb begin
    w_state_nxt    = r_state;
    w_idx_nxt      = r_idx;
    w_adr_nxt      = r_adr;
    w_wdat_nxt     = r_wdat;
    w_sel_nxt      = r_sel;
    w_we_nxt       = r_we;
    w_cnt_nxt      = r_cnt;
    w_ack_nxt      = 1'b0;
    w_err_nxt      = 1'b0;
    w_rdat_nxt     = '0;
    w_tmo_nxt      = 1'b0;
    w_tmo_addr_nxt = r_tmo_addr;
    unique case (r_state)
      StIdle: begin
        if (wbs_cyc_i && wbs_stb_i) begin
          if (w_hit) begin
            w_idx_nxt   = w_hit_idx;
            w_adr_nxt   = wbs_adr_i;
            w_wdat_nxt  = wbs_dat_i;
            w_sel_nxt   = wbs_sel_i;
            w_we_nxt    = wbs_we_i;
            w_cnt_nxt   = '0;
            w_state_nxt = StBusy;
          end else begin
            w_err_nxt   = 1'b1;
            w_state_nxt = StResp;
          end
        end
      end
      StBusy: begin
        // Abort wins over any response arriving in the same cycle.
        if (!wbs_cyc_i) begin
          w_state_nxt = StIdle;
        end else if (w_sel_err) begin
          w_err_nxt   = 1'b1;
          w_state_nxt = StResp;
        end else if (w_sel_ack) begin
          w_ack_nxt   = 1'b1;
          w_rdat_nxt  = w_sel_dat;
          w_state_nxt = StResp;
        end else if (r_cnt == TmoLast) begin
          w_err_nxt      = 1'b1;
          w_tmo_nxt      = 1'b1;
          w_tmo_addr_nxt = r_adr;
          w_state_nxt    = StResp;
        end else begin
          w_cnt_nxt = r_cnt + TMO_CNT_W'(1);
        end
      end
      StResp: begin
        w_state_nxt = StIdle;
      end
      default: begin
        w_state_nxt = StIdle;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rstn_i) begin
      r_state    <= StIdle;
      r_idx      <= '0;
      r_adr      <= '0;
      r_wdat     <= '0;
      r_sel      <= '0;
      r_we       <= 1'b0;
      r_cnt      <= '0;
      r_ack      <= 1'b0;
      r_err      <= 1'b0;
      r_rdat     <= '0;
      r_tmo      <= 1'b0;
      r_tmo_addr <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_idx      <= w_idx_nxt;
      r_adr      <= w_adr_nxt;
      r_wdat     <= w_wdat_nxt;
      r_sel      <= w_sel_nxt;
      r_we       <= w_we_nxt;
      r_cnt      <= w_cnt_nxt;
      r_ack      <= w_ack_nxt;
      r_err      <= w_err_nxt;
      r_rdat     <= w_rdat_nxt;
      r_tmo      <= w_tmo_nxt;
      r_tmo_addr <= w_tmo_addr_nxt;
    end
  end

  assign wbs_ack_o  = r_ack;
  assign wbs_err_o  = r_err;
  assign wbs_dat_o  = r_rdat;
  assign tmo_o      = r_tmo;
  assign tmo_addr_o = r_tmo_addr;

endmodule
